status_handshake_tx: RTL and testbench
======================================

Name: status_handshake_tx

Overview:
- Initiator side of the 4-bit req/ack four-phase status link.
- Watches a local status vector of anomaly flags (bit set = sensor out of range, 0000 = all OK) and transmits it to the far-end receiver whenever it differs from the last value acknowledged.
- Sits at the sensor/controller edge of the design, driving data/req toward the pump-control receiver, and takes the receiver's ack back through a synchronizer.

Parameters:
- DATA_WIDTH, 4, width of the status word and data bus.
- SYNC_STAGES, 2, flip-flop stages on ack_in (minimum 2).
- TIMEOUT_CYCLES, 50000, cycles allowed in each wait state before abort (1 ms at 50 MHz).
- HEARTBEAT_CYCLES, 50000000, idle period before a forced resend (optional feature only).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset (0 = reset)
- status_in  in  DATA_WIDTH  current local status flags, synchronous to clk
- ack_in  in  1  acknowledge from receiver, asynchronous, synchronized internally
- data_out  out  DATA_WIDTH  status word on the link, registered
- req_out  out  1  request strobe, registered
- busy_out  out  1  high in any state other than IDLE
- done_pulse_out  out  1  one-cycle pulse when a transfer completes (ack seen low)
- timeout_err_out  out  1  sticky abort flag, cleared by the next successful transfer

Behaviour:
- Reset (reset=0, async):
  - data_out=0, req_out=0, busy_out=0, done_pulse_out=0, timeout_err_out=0.
  - last_sent register=0; ack synchronizer=0; timeout counter=0; FSM=IDLE.
  - A status of 0000 at reset release therefore causes no transfer.
- ack_s is ack_in after SYNC_STAGES flops. All FSM decisions use ack_s only.
- IDLE:
  - If status_in != last_sent and ack_s==0: latch status_in into data_out and a shadow register, then go to SETUP.
  - If ack_s==1, stay in IDLE; a stale ack blocks new requests.
- SETUP: one cycle with data stable and req_out=0 (data setup time). Next cycle: req_out<=1, go to REQ_HIGH.
- REQ_HIGH: wait for ack_s==1, then req_out<=0 and go to REQ_LOW.
- REQ_LOW:
  - Wait for ack_s==0.
  - Then last_sent<=shadow, done_pulse_out=1 for one cycle, timeout_err_out<=0, go to IDLE.
- data_out is held constant from SETUP until return to IDLE; it must never change while req_out=1 or ack_s=1.
- Latency: status change sampled at edge N gives data_out valid at N+1 and req_out high at N+2. Ack rising at the pin is seen SYNC_STAGES edges later, and req_out falls one edge after that.
- Timeout:
  - The counter clears on entry to REQ_HIGH and to REQ_LOW, and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1: req_out<=0, timeout_err_out<=1, go to IDLE. last_sent is not updated.
  - The word is retried automatically once ack_s==0.
- status_in changes during a transfer are ignored; the in-flight word completes. On return to IDLE the new value is compared and sent next, so intermediate values may be skipped.
- Rapid toggling, e.g. A→B→A within one transfer of A: no second transfer.
- Reset asserted mid-transfer: outputs drop immediately (async) and last_sent returns to 0.
- No arithmetic beyond the counter. The counter width is clog2(max(TIMEOUT_CYCLES, HEARTBEAT_CYCLES)) and it saturates; it never wraps.

Optional Feature:
- Macro: STATUS_TX_HEARTBEAT_EN.
- When defined: an idle counter runs in IDLE and clears on any transfer start. When it reaches HEARTBEAT_CYCLES-1 with ack_s==0, the current status_in is sent even if it equals last_sent, so the receiver resynchronizes after glitches.
- When undefined: no idle counter; transfers occur only on change or timeout retry.

Test Plan:
- Reset release, status_in=0000, ack tied low for 100 cycles → req_out stays 0, busy_out=0, no done pulse.
- status_in=0100 with a well-behaved responder (ack rises 3 cycles after req, falls 3 cycles after req drops) → data_out=0100 one cycle before req_out=1, data stable throughout, one done pulse, last_sent=0100. Then status_in=0000 → second transfer of 0000.
- status_in changes 0100→1010 while req_out=1 → 0100 completes first, then 1010 is sent; exactly two done pulses.
- Responder never acks, TIMEOUT_CYCLES=16 → req_out drops after 16 cycles in REQ_HIGH and timeout_err_out=1. Enable the responder → retry succeeds and timeout_err_out returns to 0.
- ack_in held high at an IDLE status change → no req_out until ack_in low. Also: reset pulsed during REQ_HIGH → req_out=0 and data_out=0 within the same cycle.
- With STATUS_TX_HEARTBEAT_EN and HEARTBEAT_CYCLES=64, status constant at 0010 → resend every ~64+handshake cycles. Without the macro → no resend.

Source files
------------

// File: rtl/status_handshake_tx_if.sv
// -----------------------------------------------------------------------------
// status_handshake_tx_if
//   Four-phase status link between the sensor-side initiator and the
//   pump-control receiver.
//
//   Handshake: the initiator places a word on data_out, then raises req_out.
//   The receiver raises ack_in once it has taken the word. The initiator then
//   drops req_out, and the receiver drops ack_in. data_out is stable whenever
//   req_out or ack_in is high. ack_in is asynchronous to the initiator clock.
//
//   Signals:
//     data_out  initiator -> receiver  status word (DATA_WIDTH bits)
//     req_out   initiator -> receiver  request strobe
//     ack_in    receiver  -> initiator acknowledge
//   Modports: master (initiator side), slave (receiver side).
// -----------------------------------------------------------------------------
interface status_handshake_tx_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  req_out;
    logic                  ack_in;

    modport master (output data_out, output req_out, input ack_in);
    modport slave  (input data_out, input req_out, output ack_in);
endinterface

// File: rtl/status_handshake_tx.sv
// -----------------------------------------------------------------------------
// status_handshake_tx
//   Initiator side of the four-phase status link. Whenever the local anomaly
//   vector differs from the last word the receiver acknowledged, that vector
//   is sent over the link. Each wait state is guarded by a timeout; after a
//   timeout the word is retried once the receiver's ack has dropped.
//
//   Optional build macro: STATUS_TX_HEARTBEAT_EN
//     When defined, a word that has not changed is resent after
//     HEARTBEAT_CYCLES idle cycles, so the receiver resynchronizes after
//     glitches.
//
//   Ports:
//     clk              system clock
//     reset            asynchronous active-low reset
//     status_in        local status flags (synchronous to clk)
//     link             status link, master modport (data_out/req_out/ack_in)
//     busy_out         high whenever the FSM is not in IDLE
//     done_pulse_out   one-cycle pulse when a transfer completes
//     timeout_err_out  sticky abort flag, cleared by the next good transfer
//     state_dbg_out    current FSM state, for observation
// -----------------------------------------------------------------------------
module status_handshake_tx #(
    parameter int DATA_WIDTH       = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int TIMEOUT_CYCLES   = 50000,
    parameter int HEARTBEAT_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] status_in,
    status_handshake_tx_if.master link,
    output logic                  busy_out,
    output logic                  done_pulse_out,
    output logic                  timeout_err_out,
    output logic [1:0]            state_dbg_out
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETUP    = 2'd1;
    localparam logic [1:0] REQ_HIGH = 2'd2;
    localparam logic [1:0] REQ_LOW  = 2'd3;

    localparam int CNT_MAX = (TIMEOUT_CYCLES > HEARTBEAT_CYCLES) ? TIMEOUT_CYCLES
                                                                 : HEARTBEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
`ifdef STATUS_TX_HEARTBEAT_EN
    localparam logic [CNT_W-1:0] HEARTBEAT_LAST = CNT_W'(HEARTBEAT_CYCLES - 1);
`endif

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] last_sent_q, last_sent_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                  ack_s;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  start_xfer;

    // Ack synchronizer: ack_in enters at bit 0, ack_s is the last stage.
    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], link.ack_in};
    assign ack_s      = ack_sync_q[SYNC_STAGES-1];

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    // A stale ack from the receiver blocks any new request.
`ifdef STATUS_TX_HEARTBEAT_EN
    assign start_xfer = !ack_s && ((status_in != last_sent_q) || (cnt_q == HEARTBEAT_LAST));
`else
    assign start_xfer = !ack_s && (status_in != last_sent_q);
`endif

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        shadow_d    = shadow_q;
        last_sent_d = last_sent_q;
        req_d       = req_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
`ifdef STATUS_TX_HEARTBEAT_EN
                cnt_d = cnt_inc;
`else
                cnt_d = '0;
`endif
                if (start_xfer) begin
                    data_d   = status_in;
                    shadow_d = status_in;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                // Data has been on the bus for one full cycle; raise req now.
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = REQ_HIGH;
            end
            REQ_HIGH: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ_LOW;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            REQ_LOW: begin
                if (!ack_s) begin
                    last_sent_d = shadow_q;
                    done_d      = 1'b1;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // last_sent is left alone so the word is retried.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                req_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            shadow_q    <= '0;
            last_sent_q <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            ack_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            shadow_q    <= shadow_d;
            last_sent_q <= last_sent_d;
            req_q       <= req_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            ack_sync_q  <= ack_sync_d;
        end
    end

    assign link.data_out   = data_q;
    assign link.req_out    = req_q;
    assign busy_out        = (state_q != IDLE);
    assign done_pulse_out  = done_q;
    assign timeout_err_out = err_q;
    assign state_dbg_out   = state_q;
endmodule

// File: tb/tb_status_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_status_handshake_tx
//   Bench for status_handshake_tx with a behavioural receiver on the link.
//   Words expected on the link are queued when status_in is driven and
//   checked when done_pulse_out fires.
// -----------------------------------------------------------------------------
module tb_status_handshake_tx;
    localparam int DW = 4;
    localparam int SS = 2;
    localparam int TO = 16;
    localparam int HB = 64;
`ifdef STATUS_TX_HEARTBEAT_EN
    localparam int IDLE_WAIT = 60;
`else
    localparam int IDLE_WAIT = 100;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] status_in = '0;
    logic          busy_out;
    logic          done_pulse_out;
    logic          timeout_err_out;
    logic [1:0]    state_dbg_out;

    always #10 clk = ~clk;

    status_handshake_tx_if #(.DATA_WIDTH(DW)) link();

    status_handshake_tx #(
        .DATA_WIDTH(DW), .SYNC_STAGES(SS),
        .TIMEOUT_CYCLES(TO), .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clk(clk), .reset(reset), .status_in(status_in), .link(link),
        .busy_out(busy_out), .done_pulse_out(done_pulse_out),
        .timeout_err_out(timeout_err_out), .state_dbg_out(state_dbg_out)
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    int            stab_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_last = '0;
    logic [DW-1:0] cap = '0;
    logic [DW-1:0] data_prev = '0;
    logic          req_prev = 1'b0;
    logic          busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- receiver model ----------------
    logic resp_en = 1'b1;
    logic ack_hold = 1'b0;
    int   rs = 0;
    int   rcnt = 0;

    initial begin
        link.ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_hold) begin
                link.ack_in = 1'b1;
                rs = 0;
            end else if (!resp_en) begin
                link.ack_in = 1'b0;
                rs = 0;
            end else begin
                case (rs)
                    0: begin
                        link.ack_in = 1'b0;
                        if (link.req_out) begin rcnt = 1; rs = 1; end
                    end
                    1: if (rcnt == 3) begin link.ack_in = 1'b1; rs = 2; end else rcnt++;
                    2: if (!link.req_out) begin rcnt = 1; rs = 3; end
                    default: if (rcnt == 3) begin link.ack_in = 1'b0; rs = 0; end else rcnt++;
                endcase
            end
        end
    end

    // ---------------- link monitor ----------------
    always @(negedge clk) begin
        if (link.req_out && !req_prev) begin
            cap = link.data_out;
            // Word must already have been on the bus during SETUP.
            check("data_setup", {busy_prev, data_prev}, {1'b1, link.data_out});
        end
        if (link.req_out && (link.data_out != cap)) stab_err++;
        if (done_pulse_out) begin
            done_cnt++;
            if (exp_q.size() != 0) begin
                check("sent_word", cap, exp_q.pop_front());
            end else begin
`ifdef STATUS_TX_HEARTBEAT_EN
                check("heartbeat_word", cap, model_last);
`else
                check("unexpected_done", 1, 0);
`endif
            end
        end
        req_prev  = link.req_out;
        data_prev = link.data_out;
        busy_prev = busy_out;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] v);
        exp_q.push_back(v);
        model_last = v;
    endtask

    task automatic wait_done(input int n, input string name);
        int target;
        target = done_cnt + n;
        for (int i = 0; i < 400 && done_cnt < target; i++) tick();
        check(name, done_cnt, target);
    endtask

    task automatic wait_req_high(input string name);
        for (int i = 0; i < 60 && !link.req_out; i++) tick();
        check(name, link.req_out, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] status;
        int            exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        int hi_cnt;

        vecs[0] = '{4'b0100, 1};
        vecs[1] = '{4'b0000, 1};
        vecs[2] = '{4'b0000, 0};
        vecs[3] = '{4'b1111, 1};
        vecs[4] = '{4'b1111, 0};
        vecs[5] = '{4'b0001, 1};
        vecs[6] = '{4'b1000, 1};
        vecs[7] = '{4'b0000, 1};

        // Reset state
        repeat (3) tick();
        check("rst_data", link.data_out, 0);
        check("rst_req", link.req_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_pulse_out, 0);
        check("rst_err", timeout_err_out, 0);
        check("rst_state", state_dbg_out, 0);
        reset = 1'b1;

        // 0000 at reset release: nothing to send
        repeat (IDLE_WAIT) tick();
        check("idle_req", link.req_out, 0);
        check("idle_busy", busy_out, 0);
        check("idle_done_cnt", done_cnt, 0);

        // Table-driven transfers
        for (int i = 0; i < 8; i++) begin
            status_in = vecs[i].status;
            if (vecs[i].status != model_last) push_word(vecs[i].status);
            if (vecs[i].exp_done != 0) begin
                wait_done(1, "vec_done");
            end else begin
                base = done_cnt;
                repeat (20) tick();
                check("vec_no_done", done_cnt, base);
            end
            check("vec_data_hold", link.data_out, vecs[i].status);
            check("vec_idle", busy_out, 0);
            check("vec_err", timeout_err_out, 0);
        end

        // Status changes while req is high: in-flight word first, then new one
        status_in = 4'b0100;
        push_word(4'b0100);
        wait_req_high("chg_req");
        status_in = 4'b1010;
        push_word(4'b1010);
        wait_done(2, "chg_two_done");

        // A -> B -> A inside one transfer: one transfer only
        status_in = 4'b0101;
        push_word(4'b0101);
        wait_req_high("toggle_req");
        status_in = 4'b0011;
        tick();
        status_in = 4'b0101;
        wait_done(1, "toggle_done");
        base = done_cnt;
        repeat (30) tick();
        check("toggle_no_second", done_cnt, base);

        // Stale ack blocks a new request
        ack_hold = 1'b1;
        repeat (4) tick();
        status_in = 4'b1110;
        repeat (10) tick();
        check("stale_req", link.req_out, 0);
        check("stale_busy", busy_out, 0);
        ack_hold = 1'b0;
        push_word(4'b1110);
        wait_done(1, "stale_done");

        // Receiver silent: timeout after TO cycles of req, then retry succeeds
        resp_en = 1'b0;
        status_in = 4'b1100;
        push_word(4'b1100);
        wait_req_high("to_req");
        hi_cnt = 0;
        while (link.req_out && hi_cnt < 100) begin
            hi_cnt++;
            tick();
        end
        check("to_req_cycles", hi_cnt, TO);
        check("to_err_set", timeout_err_out, 1);
        resp_en = 1'b1;
        wait_done(1, "to_retry_done");
        check("to_err_clr", timeout_err_out, 0);

        // Reset during REQ_HIGH: outputs drop immediately, word resent after
        status_in = 4'b0110;
        push_word(4'b0110);
        wait_req_high("rstx_req");
        #3;
        reset = 1'b0;
        #1;
        check("rstx_req_low", link.req_out, 0);
        check("rstx_data_zero", link.data_out, 0);
        check("rstx_busy", busy_out, 0);
        exp_q.delete();
        model_last = '0;
        resp_en = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        resp_en = 1'b1;
        push_word(4'b0110);
        wait_done(1, "rstx_resend");

        // Constant status: heartbeat resends only when enabled
        base = done_cnt;
        repeat (200) tick();
`ifdef STATUS_TX_HEARTBEAT_EN
        check("heartbeat_resends", (done_cnt - base) >= 2, 1);
`else
        check("no_heartbeat", done_cnt, base);
`endif

        check("data_stable", stab_err, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
